// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-time registers, increment-button steering and IDLE/RINGING/SNOOZE sequencing.
// Latency: steering outputs are combinational; alarm registers and ringer/snooze indicators update on the next clk_pi edge.
// Backpressure: none; every input pulse is consumed in the cycle it is presented.
//
// Ports:
//   clk_pi, reset_pi (async, active-high), clk_en_pi (1 Hz one-cycle tick)
//   set_alarm_pi, increment_minute_pi, increment_hour_pi : button steering / alarm edit
//   alarm_on_pi, snooze_pi                               : alarm enable switch, snooze button
//   seconds_pi, minutes_pi, hours_pi                     : running clock time
//   clk_inc_minute_po, clk_inc_hour_po                   : increments forwarded to the clock datapath
//   alarm_minutes_po, alarm_hours_po                     : alarm setting
//   ringing_po, snoozing_po                              : buzzer enable, snooze indicator
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk_pi,
  input  logic       reset_pi,
  input  logic       clk_en_pi,
  input  logic       set_alarm_pi,
  input  logic       increment_minute_pi,
  input  logic       increment_hour_pi,
  input  logic       alarm_on_pi,
  input  logic       snooze_pi,
  input  logic [5:0] seconds_pi,
  input  logic [5:0] minutes_pi,
  input  logic [3:0] hours_pi,
  output logic       clk_inc_minute_po,
  output logic       clk_inc_hour_po,
  output logic [5:0] alarm_minutes_po,
  output logic [3:0] alarm_hours_po,
  output logic       ringing_po,
  output logic       snoozing_po
);

  localparam logic [7:0]  RING_LOAD = 8'(RING_TIMEOUT_S);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_ring_cnt;
  logic [7:0]  w_ring_cnt_nxt;
  logic [11:0] r_snz_cnt;
  logic [11:0] w_snz_cnt_nxt;
  logic [5:0]  r_alarm_min;
  logic [3:0]  r_alarm_hr;
  logic        r_match_q;
  logic        r_ringing;
  logic        r_snoozing;
  logic        w_match;
  logic        w_trigger;

  // Button steering: while setting the alarm the clock datapath sees nothing.
  assign clk_inc_minute_po = increment_minute_pi & ~set_alarm_pi;
  assign clk_inc_hour_po   = increment_hour_pi   & ~set_alarm_pi;

  assign alarm_minutes_po = r_alarm_min;
  assign alarm_hours_po   = r_alarm_hr;
  assign ringing_po       = r_ringing;
  assign snoozing_po      = r_snoozing;

  // Alarm time registers; minute and hour wrap independently (no carry).
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      r_alarm_min <= 6'd0;
      r_alarm_hr  <= 4'd12;
    end else if (set_alarm_pi) begin
      if (increment_minute_pi) begin
        r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
      end
      if (increment_hour_pi) begin
        r_alarm_hr <= (r_alarm_hr == 4'd12) ? 4'd1 : r_alarm_hr + 4'd1;
      end
    end
  end

  // Match uses the alarm value before this cycle's edit, so an edit that
  // lands on the current time only rings at the next hh:mm:00 edge.
  assign w_match   = (hours_pi == r_alarm_hr) && (minutes_pi == r_alarm_min) &&
                     (seconds_pi == 6'd0);
  assign w_trigger = w_match & ~r_match_q;

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    if (!alarm_on_pi) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            w_state_nxt    = S_RINGING;
            w_ring_cnt_nxt = RING_LOAD;
          end
        end
        S_RINGING: begin
          // Snooze outranks the final ring tick.
          if (snooze_pi) begin
            w_state_nxt   = S_SNOOZE;
            w_snz_cnt_nxt = SNZ_LOAD;
          end else if (clk_en_pi) begin
            if (r_ring_cnt == 8'd1) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt - 8'd1;
            end
          end
        end
        S_SNOOZE: begin
          if (clk_en_pi) begin
            if (r_snz_cnt == 12'd1) begin
              w_state_nxt    = S_RINGING;
              w_ring_cnt_nxt = RING_LOAD;
            end else begin
              w_snz_cnt_nxt = r_snz_cnt - 12'd1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // match_q resets high so a time already sitting on the alarm at reset
  // release is not seen as a fresh edge.
  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      r_state    <= S_IDLE;
      r_ring_cnt <= 8'd0;
      r_snz_cnt  <= 12'd0;
      r_match_q  <= 1'b1;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_match_q  <= w_match;
      r_ringing  <= (w_state_nxt == S_RINGING);
      r_snoozing <= (w_state_nxt == S_SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: randomized + directed stimulus against a seconds-remaining reference model.
// Expected outputs are queued per cycle by the driver and popped by an independent monitor.
// The bench acts as the running clock, advancing its own time on each clk_en tick.
module tb_alarm_ctrl;

  localparam int T_RING = 5;
  localparam int S_MIN  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en, set_alarm, inc_min, inc_hr, alarm_on, snooze;
  logic [5:0] sec_in, min_in;
  logic [3:0] hr_in;
  logic       clk_inc_min, clk_inc_hr, ringing, snoozing;
  logic [5:0] alarm_min;
  logic [3:0] alarm_hr;

  always #5 clk = ~clk;

  alarm_ctrl #(.SNOOZE_MIN(S_MIN), .RING_TIMEOUT_S(T_RING)) dut (
    .clk_pi(clk), .reset_pi(reset), .clk_en_pi(clk_en),
    .set_alarm_pi(set_alarm), .increment_minute_pi(inc_min),
    .increment_hour_pi(inc_hr), .alarm_on_pi(alarm_on), .snooze_pi(snooze),
    .seconds_pi(sec_in), .minutes_pi(min_in), .hours_pi(hr_in),
    .clk_inc_minute_po(clk_inc_min), .clk_inc_hour_po(clk_inc_hr),
    .alarm_minutes_po(alarm_min), .alarm_hours_po(alarm_hr),
    .ringing_po(ringing), .snoozing_po(snoozing)
  );

  typedef struct {
    bit ring;
    bit snz;
    bit cm;
    bit ch;
    int amin;
    int ahr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: alarm time as integers, ringing/snoozing flags with seconds left.
  int m_amin, m_ahr, m_ring_left, m_snz_left;
  bit m_prev, m_ring, m_snz;
  // Bench-owned wall clock.
  int th, tm, ts;
  bit freeze;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_amin = 0; m_ahr = 12; m_prev = 1'b1;
    m_ring = 1'b0; m_snz = 1'b0; m_ring_left = 0; m_snz_left = 0;
  endtask

  task automatic model_step(input bit en, input bit sa, input bit im, input bit ih,
                            input bit on, input bit sz, input int h, input int m, input int s);
    bit match, trig;
    match  = (h == m_ahr) && (m == m_amin) && (s == 0);
    trig   = match && !m_prev;
    m_prev = match;
    if (sa) begin
      if (im) m_amin = (m_amin + 1) % 60;
      if (ih) m_ahr  = m_ahr % 12 + 1;
    end
    if (!on) begin
      m_ring = 1'b0; m_snz = 1'b0;
    end else if (m_ring) begin
      if (sz) begin
        m_ring = 1'b0; m_snz = 1'b1; m_snz_left = S_MIN * 60;
      end else if (en) begin
        if (m_ring_left == 1) m_ring = 1'b0;
        else m_ring_left--;
      end
    end else if (m_snz) begin
      if (en) begin
        if (m_snz_left == 1) begin
          m_snz = 1'b0; m_ring = 1'b1; m_ring_left = T_RING;
        end else m_snz_left--;
      end
    end else if (trig) begin
      m_ring = 1'b1; m_ring_left = T_RING;
    end
  endtask

  task automatic advance();
    ts++;
    if (ts == 60) begin
      ts = 0; tm++;
      if (tm == 60) begin
        tm = 0; th = th % 12 + 1;
      end
    end
  endtask

  // One clock cycle: drive at negedge, queue the model's post-edge view.
  task automatic cyc(input bit en, input bit sa, input bit im, input bit ih,
                     input bit on, input bit sz);
    exp_t e;
    @(negedge clk);
    clk_en = en; set_alarm = sa; inc_min = im; inc_hr = ih; alarm_on = on; snooze = sz;
    hr_in = 4'(th); min_in = 6'(tm); sec_in = 6'(ts);
    model_step(en, sa, im, ih, on, sz, th, tm, ts);
    e.ring = m_ring; e.snz = m_snz; e.cm = im & ~sa; e.ch = ih & ~sa;
    e.amin = m_amin; e.ahr = m_ahr;
    sb.push_back(e);
    @(posedge clk);
    if (en && !freeze) advance();
  endtask

  // Put the bench clock two seconds before the alarm time.
  task automatic near_alarm();
    tm = (m_amin + 59) % 60;
    th = (m_amin == 0) ? ((m_ahr + 10) % 12 + 1) : m_ahr;
    ts = 58;
  endtask

  task automatic ring_up();
    cyc(0, 0, 0, 0, 0, 0);
    near_alarm();
    for (int i = 0; i < 12 && !m_ring; i++) cyc(1, 0, 0, 0, 1, 0);
    #2;
    chk("ring_up", int'(ringing), 1);
  endtask

  // Monitor: compares every DUT output against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ringing",     int'(ringing),     int'(e.ring));
        chk("snoozing",    int'(snoozing),    int'(e.snz));
        chk("clk_inc_min", int'(clk_inc_min), int'(e.cm));
        chk("clk_inc_hr",  int'(clk_inc_hr),  int'(e.ch));
        chk("alarm_min",   int'(alarm_min),   e.amin);
        chk("alarm_hr",    int'(alarm_hr),    e.ahr);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; clk_en = 0; set_alarm = 0; inc_min = 0; inc_hr = 0;
    alarm_on = 1; snooze = 0;
    th = 12; tm = 0; ts = 0; freeze = 1'b0;
    hr_in = 4'd12; min_in = 6'd0; sec_in = 6'd0;
    model_reset();

    // Reset values, then release with the clock already on 12:00:00 and the alarm on.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ringing", int'(ringing), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    chk("rst_alarm_min", int'(alarm_min), 0);
    chk("rst_alarm_hr", int'(alarm_hr), 12);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (4) cyc(0, 0, 0, 0, 1, 0);

    // Steering to the clock, then 61 minute pulses and one hour pulse into the alarm.
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 61; i++) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1, 0);
    #2;
    chk("alarm_0101_min", int'(alarm_min), 1);
    chk("alarm_0101_hr", int'(alarm_hr), 1);

    // Program 06:30 (both buttons together for the first five pulses).
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 24; i++) cyc(0, 1, 1, 0, 1, 0);
    #2;
    chk("alarm_0630_min", int'(alarm_min), 30);
    chk("alarm_0630_hr", int'(alarm_hr), 6);

    // Ring and time out with the clock frozen at 06:30:00: no re-trigger.
    ring_up();
    freeze = 1'b1; ts = 0;
    for (int i = 0; i < T_RING + 4; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    freeze = 1'b0;

    // Snooze: 59 ticks stay in snooze, the 60th rings; snooze again and ignore a snooze press.
    ring_up();
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 59; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
    end
    #2;
    chk("snz_59_ticks", int'(snoozing), 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 1, (i == 10));

    // Disable together with snooze while ringing; then a matching time with the alarm off.
    ring_up();
    cyc(0, 0, 0, 0, 0, 1);
    near_alarm();
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);

    // Edit the alarm minute while ringing.
    ring_up();
    cyc(0, 1, 1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 1, 0);

    // Randomized traffic around the alarm time.
    for (int i = 0; i < 1500; i++) begin
      bit en, sa, im, ih, on, sz;
      if ($urandom_range(59) == 0) near_alarm();
      en = $urandom_range(1);
      sa = ($urandom_range(24) == 0);
      im = $urandom_range(1);
      ih = ($urandom_range(3) == 0);
      on = ($urandom_range(29) != 0);
      sz = ($urandom_range(11) == 0);
      cyc(en, sa, im, ih, on, sz);
    end

    // Asynchronous reset mid-snooze, then release on 12:00:00 with the alarm on.
    ring_up();
    cyc(0, 0, 0, 0, 1, 1);
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    #2;
    chk("pre_reset_snoozing", int'(snoozing), int'(m_snz));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_snoozing", int'(snoozing), 0);
    chk("async_rst_ringing", int'(ringing), 0);
    chk("async_rst_alarm_min", int'(alarm_min), 0);
    chk("async_rst_alarm_hr", int'(alarm_hr), 12);
    th = 12; tm = 0; ts = 0;
    hr_in = 4'd12; min_in = 6'd0; sec_in = 6'd0;
    clk_en = 0; snooze = 0; set_alarm = 0; inc_min = 0; inc_hr = 0; alarm_on = 1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    repeat (5) cyc(0, 0, 0, 0, 1, 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm and snooze controller for the 12-hour clock. It owns the alarm-time registers and steers the user's minute/hour increment buttons either to the clock datapath or to the alarm registers. It watches the running clock time and sequences the IDLE → RINGING → SNOOZE behaviour, driving the ringer and snooze indicators. It sits between the button debouncers, the clock state machine and the display/buzzer logic, on the same 1 Hz `clk_en_pi` tick.

## Interface
- `SNOOZE_MIN`, default 5: snooze length in minutes, legal range 1..59.
- `RING_TIMEOUT_S`, default 60: seconds of ringing before auto-stop, legal range 1..255.

- `clk_pi` input 1: system clock; all state changes on its rising edge.
- `reset_pi` input 1: asynchronous, active-high reset.
- `clk_en_pi` input 1: one-cycle pulse, once per second.
- `set_alarm_pi` input 1: level. 1 routes the increment buttons to the alarm registers.
- `increment_minute_pi` input 1: one-cycle button pulse.
- `increment_hour_pi` input 1: one-cycle button pulse.
- `alarm_on_pi` input 1: level, alarm enable switch.
- `snooze_pi` input 1: one-cycle button pulse.
- `seconds_pi` input 6: current clock seconds, 0..59.
- `minutes_pi` input 6: current clock minutes, 0..59.
- `hours_pi` input 4: current clock hours, 1..12.
- `clk_inc_minute_po` output 1: minute increment to the clock datapath.
- `clk_inc_hour_po` output 1: hour increment to the clock datapath.
- `alarm_minutes_po` output 6: alarm minute setting.
- `alarm_hours_po` output 4: alarm hour setting.
- `ringing_po` output 1: buzzer enable.
- `snoozing_po` output 1: snooze indicator.

## Operation
- **Button steering (combinational):**
  - `clk_inc_minute_po = increment_minute_pi & ~set_alarm_pi`; `clk_inc_hour_po` is formed the same way.
  - With `set_alarm_pi`=1, the clock datapath never sees an increment.
- **Alarm registers** (`alarm_minutes`, `alarm_hours`):
  - Update only when `set_alarm_pi`=1.
  - Minute: 59 wraps to 0. Hour: 12 wraps to 1. No carry from minute to hour.
  - Minute and hour pulses in the same cycle both apply.
  - Editing is allowed in any state and never changes the state.
- **Match detection:**
  - `match = (hours_pi==alarm_hours) && (minutes_pi==alarm_minutes) && (seconds_pi==0)`.
  - `match_q` is the registered copy of `match`; it resets to 1, which suppresses a trigger on the first cycle after reset.
  - `trigger = match & ~match_q`, i.e. the rising edge of `match`.
- **States:** IDLE, RINGING, SNOOZE. Transitions in priority order:
  1. `alarm_on_pi`=0 → IDLE, from any state.
  2. IDLE: `trigger` → RINGING; load `ring_cnt`=`RING_TIMEOUT_S`.
  3. RINGING:
     - `snooze_pi` → SNOOZE; load `snz_cnt`=`SNOOZE_MIN*60`.
     - Otherwise, on `clk_en_pi`: if `ring_cnt`==1 → IDLE, else decrement `ring_cnt`.
  4. SNOOZE: on `clk_en_pi`, if `snz_cnt`==1 → RINGING (load `ring_cnt`=`RING_TIMEOUT_S`), else decrement `snz_cnt`.
- **Ignored inputs:**
  - `snooze_pi` in IDLE or SNOOZE.
  - `trigger` in RINGING or SNOOZE; a new day's match is still edge-detected afterwards.
- **Counter widths:** `snz_cnt` is 12 bits (max 3540). `ring_cnt` is 8 bits. Decrements never underflow, because the ==1 check comes first.
- **Outputs:** `ringing_po` = (state==RINGING); `snoozing_po` = (state==SNOOZE). Both are registered.

## Timing
- **Reset values:**
  - State IDLE; `ringing_po`=0, `snoozing_po`=0.
  - `alarm_hours_po`=12, `alarm_minutes_po`=0.
  - `ring_cnt`=0, `snz_cnt`=0, `match_q`=1.
- **Reset asserted mid-RINGING or mid-SNOOZE:** outputs clear immediately (asynchronous), and the alarm setting returns to 12:00.
- **Latency:**
  - `ringing_po` rises on the first `clk_pi` edge at which `match`=1 and `match_q`=0, i.e. one cycle after the clock inputs show hh:mm:00.
  - `snooze_pi` drops `ringing_po` and raises `snoozing_po` on the next edge.
  - `alarm_*_po` update on the edge that samples the increment pulse.
  - Steering outputs have zero latency.
- **Ring duration:** exactly `RING_TIMEOUT_S` `clk_en_pi` pulses after entry; the state leaves RINGING on the edge of the last pulse.
- **Snooze duration:** exactly `SNOOZE_MIN*60` pulses.
- **Simultaneous events:**
  - `snooze_pi` with the final ring tick → SNOOZE.
  - `alarm_on_pi`=0 with any event → IDLE.
  - Final snooze tick with `trigger` → RINGING, loaded once.

## Test plan
- **Steering:** pulse `increment_minute_pi` with `set_alarm_pi`=0 → `clk_inc_minute_po` pulses, alarm stays 12:00. With `set_alarm_pi`=1, pulse minute 61 times and hour once → `clk_inc_*_po` stay 0, alarm = 01:01.
- **Trigger and timeout** (`RING_TIMEOUT_S`=5): set alarm 06:30, `alarm_on_pi`=1, drive time 06:29:59 → 06:30:00 → `ringing_po`=1 one cycle later. After 5 `clk_en_pi` pulses → `ringing_po`=0, IDLE. Holding time at 06:30:00 causes no re-trigger.
- **Snooze** (`SNOOZE_MIN`=1): ring, pulse `snooze_pi` → `snoozing_po`=1 next cycle. After 59 ticks still SNOOZE; the 60th tick → `ringing_po`=1. A second `snooze_pi` restarts the 60 s snooze.
- **Disable priority:** in RINGING, drop `alarm_on_pi` in the same cycle as `snooze_pi` → IDLE, both indicators 0. With the alarm off, a matching time gives no ring.
- **Reset:** assert `reset_pi` mid-SNOOZE between clock edges → `snoozing_po`=0 immediately and alarm reads 12:00. Releasing reset with clock at 12:00:00 and `alarm_on_pi`=1 → no ring.
- **Edit during ring:** in RINGING, increment the alarm minute → `ringing_po` stays 1 and `alarm_minutes_po` increments.
